// File: rtl/ex_stage_fwd.sv
// ex_stage_fwd
//   Execute stage between the decode/regfile-read register and MEM. Resolves
//   source operands via forwarding from EX/MEM (highest priority) and MEM/WB,
//   evaluates the ALU op, and owns the EX/MEM output register with a
//   valid/ready handshake on both sides.
//
//   Optional multiplier: define EX_STAGE_FWD_MUL_EN to build the iterative
//   shift-add multiplier (op 7) with its IDLE/BUSY FSM. Without it, op 7
//   completes in one cycle with a zero result.
//
// Ports
//   clk, reset_n                     clock, async active-low reset
//   in_valid / in_ready              upstream handshake
//   in_op, in_use_imm, in_imm        operation select and immediate
//   in_sr1_*, in_sr2_*               source indices and regfile values
//   in_dest, in_regwrite             destination of the instruction
//   exm_*, mwb_*                     forwarding sources (EX/MEM, MEM/WB)
//   out_valid / out_ready            downstream handshake
//   out_result, out_store_data       result and forwarded sr2 value
//   out_dest, out_regwrite           destination of the held result
module ex_stage_fwd #(
    parameter int WIDTH   = 16,
    parameter int IDX_W   = 3,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_use_imm,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [IDX_W-1:0] in_sr1_idx,
    input  logic [IDX_W-1:0] in_sr2_idx,
    input  logic [WIDTH-1:0] in_sr1_val,
    input  logic [WIDTH-1:0] in_sr2_val,
    input  logic [IDX_W-1:0] in_dest,
    input  logic             in_regwrite,
    input  logic             exm_regwrite,
    input  logic [IDX_W-1:0] exm_dest,
    input  logic [WIDTH-1:0] exm_val,
    input  logic             mwb_regwrite,
    input  logic [IDX_W-1:0] mwb_dest,
    input  logic [WIDTH-1:0] mwb_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_store_data,
    output logic [IDX_W-1:0] out_dest,
    output logic             out_regwrite
);

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_AND   = 3'd1;
    localparam logic [2:0] OP_NOT   = 3'd2;
    localparam logic [2:0] OP_SHL   = 3'd3;
    localparam logic [2:0] OP_SHRL  = 3'd4;
    localparam logic [2:0] OP_SHRA  = 3'd5;
    localparam logic [2:0] OP_PASSB = 3'd6;
    localparam logic [2:0] OP_MUL   = 3'd7;

    logic [WIDTH-1:0]   w_fwdA;
    logic [WIDTH-1:0]   w_fwdB;
    logic [WIDTH-1:0]   w_opB;
    logic [WIDTH-1:0]   w_alu;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_outFree;
    logic               w_accept;
    logic               w_loadAlu;

    logic               r_outValid;
    logic [WIDTH-1:0]   r_outResult;
    logic [WIDTH-1:0]   r_outStore;
    logic [IDX_W-1:0]   r_outDest;
    logic               r_outRegwrite;

    // Forwarding: the younger EX/MEM producer wins over MEM/WB. R0 is not special.
    always_comb begin
        w_fwdA = in_sr1_val;
        if (exm_regwrite && (exm_dest == in_sr1_idx)) begin
            w_fwdA = exm_val;
        end else if (mwb_regwrite && (mwb_dest == in_sr1_idx)) begin
            w_fwdA = mwb_val;
        end
        w_fwdB = in_sr2_val;
        if (exm_regwrite && (exm_dest == in_sr2_idx)) begin
            w_fwdB = exm_val;
        end else if (mwb_regwrite && (mwb_dest == in_sr2_idx)) begin
            w_fwdB = mwb_val;
        end
    end

    assign w_opB   = in_use_imm ? in_imm : w_fwdB;
    assign w_shamt = w_opB[SHAMT_W-1:0];

    // Single-cycle ALU. MUL yields zero here; the multiplier path supplies
    // its own result when it is built.
    always_comb begin
        w_alu = '0;
        case (in_op)
            OP_ADD:   w_alu = w_fwdA + w_opB;
            OP_AND:   w_alu = w_fwdA & w_opB;
            OP_NOT:   w_alu = ~w_fwdA;
            OP_SHL:   w_alu = w_fwdA << w_shamt;
            OP_SHRL:  w_alu = w_fwdA >> w_shamt;
            OP_SHRA:  w_alu = $unsigned($signed(w_fwdA) >>> w_shamt);
            OP_PASSB: w_alu = w_opB;
            OP_MUL:   w_alu = '0;
        endcase
    end

    // The output register can take new data when empty or being consumed now.
    assign w_outFree = !r_outValid || out_ready;
    assign w_accept  = in_valid && in_ready;

`ifdef EX_STAGE_FWD_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_mulA;
    logic [WIDTH-1:0] r_mulB;
    logic [WIDTH-1:0] r_mulAcc;
    logic [WIDTH-1:0] r_mulStore;
    logic [IDX_W-1:0] r_mulDest;
    logic             r_mulRegwrite;
    logic             w_mulDone;

    assign in_ready  = (r_state == IDLE) && w_outFree;
    assign w_mulDone = (r_state == BUSY) && (r_cnt == '0) && w_outFree;
    assign w_loadAlu = w_accept && (in_op != OP_MUL);

    // Multiplier FSM: operands are frozen at acceptance, then one shift-add
    // step per cycle. Once the count is exhausted it parks in BUSY until the
    // output register can take the product.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_mulA        <= '0;
            r_mulB        <= '0;
            r_mulAcc      <= '0;
            r_mulStore    <= '0;
            r_mulDest     <= '0;
            r_mulRegwrite <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (in_op == OP_MUL)) begin
                        r_mulA        <= w_fwdA;
                        r_mulB        <= w_opB;
                        r_mulAcc      <= '0;
                        r_mulStore    <= w_fwdB;
                        r_mulDest     <= in_dest;
                        r_mulRegwrite <= in_regwrite;
                        r_cnt         <= CNT_W'(WIDTH);
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt != '0) begin
                        if (r_mulB[0]) begin
                            r_mulAcc <= r_mulAcc + r_mulA;
                        end
                        r_mulA <= {r_mulA[WIDTH-2:0], 1'b0};
                        r_mulB <= {1'b0, r_mulB[WIDTH-1:1]};
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end else if (w_outFree) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
`else
    assign in_ready  = w_outFree;
    assign w_loadAlu = w_accept;
`endif

    // EX/MEM output register: load a fresh result (possibly in the same edge
    // the old one is consumed), otherwise drop valid once consumed, else hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outValid    <= 1'b0;
            r_outResult   <= '0;
            r_outStore    <= '0;
            r_outDest     <= '0;
            r_outRegwrite <= 1'b0;
        end else if (w_loadAlu) begin
            r_outValid    <= 1'b1;
            r_outResult   <= w_alu;
            r_outStore    <= w_fwdB;
            r_outDest     <= in_dest;
            r_outRegwrite <= in_regwrite;
`ifdef EX_STAGE_FWD_MUL_EN
        end else if (w_mulDone) begin
            r_outValid    <= 1'b1;
            r_outResult   <= r_mulAcc;
            r_outStore    <= r_mulStore;
            r_outDest     <= r_mulDest;
            r_outRegwrite <= r_mulRegwrite;
`endif
        end else if (out_ready) begin
            r_outValid <= 1'b0;
        end
    end

    assign out_valid      = r_outValid;
    assign out_result     = r_outResult;
    assign out_store_data = r_outStore;
    assign out_dest       = r_outDest;
    assign out_regwrite   = r_outRegwrite;

endmodule
